// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared frame constants and FSM state encodings for the UART
//            serializer/deserializer and its bit timer.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam int   BIT_IDX_W   = $clog2(DATA_BITS);
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3,
    TX_DONE  = 3'd4
  } tx_state_e;

  // The frame receiver walks IDLE..STOP; the output register walks IDLE/HOLD
  // on its own so reception continues while a byte is being held.
  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_HOLD  = 3'd4
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_serdes_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_serdes_if
// Purpose  : Bundle of the serial lines and the byte-level handshakes.
// Ports    : slave  - the UART (drives tx/done/d_in/d_ready)
//            master - the user side (drives rx/d_out/start/ack)
// Revision : 1.0  initial release
// ============================================================================
interface uart_serdes_if;
  import uart_pkg::*;

  logic                 rx;
  logic                 tx;
  logic [DATA_BITS-1:0] d_out;
  logic                 start;
  logic                 done;
  logic [DATA_BITS-1:0] d_in;
  logic                 d_ready;
  logic                 ack;

  modport slave  (input  rx, d_out, start, ack,
                  output tx, done, d_in, d_ready);
  modport master (output rx, d_out, start, ack,
                  input  tx, done, d_in, d_ready);
endinterface
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Purpose  : Free-running bit-period counter while enabled; strobes at the
//            bit middle and on the last cycle of the bit. Held at zero while
//            disabled so every enable starts a fresh bit.
// Ports    : clk, rst_n - clock, async active-low reset
//            en_i       - count enable
//            mid_o      - mid-bit strobe (one cycle)
//            end_o      - last-cycle-of-bit strobe (one cycle)
// Revision : 1.0  initial release
// ============================================================================
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic en_i,
  output logic      mid_o,
  output logic      end_o
);
  localparam int            CNT_W   = $clog2(CLKS_PER_BIT);
  // The receiver sees the line one synchronizer stage late, so the mid
  // strobe fires one count early to land on the true bit centre.
  localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] END_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || cnt_q == END_CNT) cnt_d = '0;
    else                           cnt_d = cnt_q + 1'b1;
  end

  assign mid_o = en_i && (cnt_q == MID_CNT);
  assign end_o = en_i && (cnt_q == END_CNT);
endmodule
`default_nettype wire

// File: rtl/uart_serdes.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_serdes
// Purpose  : 8N1 UART transmitter and receiver with level (4-phase)
//            handshakes on both byte interfaces. TX and RX are independent.
// Ports    : clk   - single clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - uart_serdes_if.slave: rx, tx, d_out, start, done,
//                    d_in, d_ready, ack
// Revision : 1.0  initial release
// ============================================================================
module uart_serdes
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  uart_serdes_if.slave bus
);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

  // --------------------------------------------------------------------------
  // Transmitter
  // --------------------------------------------------------------------------
  tx_state_e              tx_state_q, tx_state_d;
  logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic [BIT_IDX_W-1:0]   tx_bit_q,   tx_bit_d;
  logic                   tx_run, tx_end, tx_mid_unused;
  logic                   tx_line, tx_done;

  assign tx_run = (tx_state_q == TX_START) || (tx_state_q == TX_DATA) ||
                  (tx_state_q == TX_STOP);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (tx_run),
    .mid_o (tx_mid_unused),
    .end_o (tx_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    case (tx_state_q)
      TX_IDLE:  if (bus.start) tx_state_d = TX_START;
      // d_out is taken at the very end of the start bit so a FIFO read
      // issued when start rises has time to complete.
      TX_START: if (tx_end) begin
        tx_shift_d = bus.d_out;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end
      TX_DATA:  if (tx_end) begin
        tx_shift_d = tx_shift_q >> 1;
        if (tx_bit_q == LAST_BIT) tx_state_d = TX_STOP;
        else                      tx_bit_d   = tx_bit_q + 1'b1;
      end
      TX_STOP:  if (tx_end) tx_state_d = TX_DONE;
      TX_DONE:  if (!bus.start) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  // Line level decodes straight from flops; reset forces IDLE and thus
  // a high line without waiting for a clock.
  always_comb begin
    tx_line = IDLE_LEVEL;
    tx_done = 1'b0;
    case (tx_state_q)
      TX_START: tx_line = START_LEVEL;
      TX_DATA:  tx_line = tx_shift_q[0];
      TX_STOP:  tx_line = STOP_LEVEL;
      TX_DONE:  tx_done = 1'b1;
      default:  ;
    endcase
  end

  assign bus.tx   = tx_line;
  assign bus.done = tx_done;

  // --------------------------------------------------------------------------
  // Receiver: synchronizer and frame FSM
  // --------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_e              rx_state_q, rx_state_d;
  logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
  logic [BIT_IDX_W-1:0]   rx_bit_q,   rx_bit_d;
  logic                   rx_run, rx_mid, rx_end, rx_byte_done;

  assign rx_run = (rx_state_q == RX_START) || (rx_state_q == RX_DATA) ||
                  (rx_state_q == RX_STOP);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (rx_run),
    .mid_o (rx_mid),
    .end_o (rx_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_shift_q <= '0;
      rx_bit_q   <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    case (rx_state_q)
      // Edge rather than level, so a low line after a framing error is not
      // mistaken for a new start bit.
      RX_IDLE:  if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
      RX_START: begin
        if (rx_mid && rx_sync_q != START_LEVEL) rx_state_d = RX_IDLE;
        else if (rx_end) begin
          rx_bit_d   = '0;
          rx_state_d = RX_DATA;
        end
      end
      RX_DATA:  begin
        if (rx_mid) rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_end) begin
          if (rx_bit_q == LAST_BIT) rx_state_d = RX_STOP;
          else                      rx_bit_d   = rx_bit_q + 1'b1;
        end
      end
      // Leave at mid stop bit so a following start edge is not missed.
      RX_STOP:  if (rx_mid) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_byte_done = 1'b0;
    if (rx_state_q == RX_STOP && rx_mid && rx_sync_q == STOP_LEVEL)
      rx_byte_done = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Receiver: output register, pending slot and 4-phase handshake
  // --------------------------------------------------------------------------
  rx_state_e              dlv_state_q, dlv_state_d;
  logic [DATA_BITS-1:0]   d_in_q, d_in_d;
  logic [DATA_BITS-1:0]   pend_q, pend_d;
  logic                   pend_vld_q, pend_vld_d;
  logic                   dlv_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dlv_state_q <= RX_IDLE;
      d_in_q      <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
    end else begin
      dlv_state_q <= dlv_state_d;
      d_in_q      <= d_in_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
    end
  end

  // Loading only while ack is low guarantees ack was seen low since the
  // previous byte was taken.
  assign dlv_load = (dlv_state_q == RX_IDLE) && !bus.ack &&
                    (pend_vld_q || rx_byte_done);

  always_comb begin
    dlv_state_d = dlv_state_q;
    d_in_d      = d_in_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    case (dlv_state_q)
      RX_HOLD: if (bus.ack) dlv_state_d = RX_IDLE;
      default: if (dlv_load) begin
        dlv_state_d = RX_HOLD;
        d_in_d      = pend_vld_q ? pend_q : rx_shift_q;
      end
    endcase
    // A new byte that is not going straight to d_in lands in the pending
    // slot, overwriting any byte already waiting there.
    if (rx_byte_done && !(dlv_load && !pend_vld_q)) begin
      pend_d     = rx_shift_q;
      pend_vld_d = 1'b1;
    end else if (dlv_load && pend_vld_q) begin
      pend_vld_d = 1'b0;
    end
  end

  assign bus.d_in    = d_in_q;
  assign bus.d_ready = (dlv_state_q == RX_HOLD);
endmodule
`default_nettype wire

// File: tb/tb_uart_serdes.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_serdes
// Purpose  : Self-checking bench for uart_serdes with CLKS_PER_BIT=4.
//            Expected serial waveforms come from the 8N1 frame rule
//            {stop, data, start}; received bytes from a delivery model
//            (held byte plus one overwritable pending byte).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_serdes;
  localparam int CPB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_drv = 1'b1;
  logic lb    = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  uart_serdes_if bus();
  assign bus.rx = lb ? bus.tx : rx_drv;

  uart_serdes #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_pass=%0d n_total=%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] frame_of(input logic [7:0] b, input logic stop);
    return {stop, b, 1'b0};
  endfunction

  // Sends one frame and checks every cycle of the line plus the done handshake.
  task automatic tx_frame(input logic [7:0] b, input int late, input bit early_drop);
    logic [9:0] f;
    f = frame_of(b, 1'b1);
    bus.d_out = (late > 0) ? ~b : b;
    bus.start = 1'b1;
    for (int i = 0; i < 10*CPB; i++) begin
      @(negedge clk);
      if (late > 0 && i == late - 1) bus.d_out = b;
      if (i == 2*CPB) bus.d_out = 8'($urandom);
      if (early_drop && i == 2*CPB) bus.start = 1'b0;
      n_total++;
      if (bus.tx !== f[i/CPB] || bus.done !== 1'b0)
        $display("FAIL tx_bit byte=%h cyc=%0d: tx=%b done=%b, expected tx=%b done=0",
                 b, i, bus.tx, bus.done, f[i/CPB]);
      else n_pass++;
    end
    @(negedge clk);
    n_total++;
    if (bus.done !== 1'b1 || bus.tx !== 1'b1)
      $display("FAIL tx_done byte=%h: done=%b tx=%b, expected 1 1", b, bus.done, bus.tx);
    else n_pass++;
    bus.start = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.done !== 1'b0)
      $display("FAIL tx_done_drop byte=%h: done=%b, expected 0", b, bus.done);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.tx !== 1'b1)
      $display("FAIL tx_idle byte=%h: tx=%b, expected 1", b, bus.tx);
    else n_pass++;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = frame_of(b, stop);
    for (int k = 0; k < 10; k++) begin
      rx_drv = f[k];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_ready(input int budget, output logic seen);
    seen = bus.d_ready;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.d_ready === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic ack_cycle();
    bus.ack = 1'b1;
    @(negedge clk);
    bus.ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    bus.d_out = 8'h00;
    rst_n     = 1'b0;
    #2;
    n_total++;
    if (bus.tx !== 1'b1 || bus.done !== 1'b0 || bus.d_ready !== 1'b0 || bus.d_in !== 8'h00)
      $display("FAIL reset_state: tx=%b done=%b d_ready=%b d_in=%h, expected 1 0 0 00",
               bus.tx, bus.done, bus.d_ready, bus.d_in);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tx();
    tx_frame(8'hA5, 0, 1'b0);
    for (int n = 0; n < 4; n++)
      tx_frame(8'($urandom), int'($urandom_range(0, 2)), bit'(n % 2));
  endtask

  task automatic test_rx();
    logic       seen;
    logic [7:0] b;
    logic [7:0] exp_q[$];
    exp_q = {8'h3C, 8'hFF};
    for (int n = 0; n < 6; n++) exp_q.push_back(8'($urandom));
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      rx_send(b, 1'b1);
      wait_ready(20, seen);
      n_total++;
      if (seen !== 1'b1) $display("FAIL rx_ready byte=%h: d_ready never rose, expected 1", b);
      else n_pass++;
      repeat (3) begin
        @(negedge clk);
        n_total++;
        if (bus.d_ready !== 1'b1 || bus.d_in !== b)
          $display("FAIL rx_hold: d_ready=%b d_in=%h, expected 1 %h", bus.d_ready, bus.d_in, b);
        else n_pass++;
      end
      bus.ack = 1'b1;
      repeat (3) begin
        @(negedge clk);
        n_total++;
        if (bus.d_ready !== 1'b0)
          $display("FAIL rx_ack_drop: d_ready=%b, expected 0", bus.d_ready);
        else n_pass++;
      end
      bus.ack = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_overrun();
    logic       seen;
    logic [7:0] a, b, c;
    a = 8'($urandom);
    b = a ^ 8'h5A;
    c = a ^ 8'hC3;
    rx_send(a, 1'b1);
    rx_send(b, 1'b1);
    rx_send(c, 1'b1);
    repeat (5) @(negedge clk);
    n_total++;
    if (bus.d_ready !== 1'b1 || bus.d_in !== a)
      $display("FAIL overrun_keep_oldest: d_ready=%b d_in=%h, expected 1 %h", bus.d_ready, bus.d_in, a);
    else n_pass++;
    bus.ack = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (bus.d_ready !== 1'b0)
      $display("FAIL overrun_ack_high: d_ready=%b, expected 0 while ack high", bus.d_ready);
    else n_pass++;
    bus.ack = 1'b0;
    wait_ready(5, seen);
    n_total++;
    if (seen !== 1'b1 || bus.d_in !== c)
      $display("FAIL overrun_pending: seen=%b d_in=%h, expected 1 %h", seen, bus.d_in, c);
    else n_pass++;
    ack_cycle();
    wait_ready(20, seen);
    n_total++;
    if (seen !== 1'b0) $display("FAIL overrun_extra: d_ready=%b, expected 0", seen);
    else n_pass++;
  endtask

  task automatic test_glitch_and_framing();
    logic       seen;
    logic [7:0] b;
    rx_drv = 1'b0;
    repeat (2) @(negedge clk);
    rx_drv = 1'b1;
    wait_ready(50, seen);
    n_total++;
    if (seen !== 1'b0) $display("FAIL glitch: d_ready=%b, expected 0", seen);
    else n_pass++;
    rx_send(8'($urandom), 1'b0);
    wait_ready(30, seen);
    n_total++;
    if (seen !== 1'b0) $display("FAIL framing: d_ready=%b, expected 0", seen);
    else n_pass++;
    b = 8'($urandom);
    rx_send(b, 1'b1);
    wait_ready(20, seen);
    n_total++;
    if (seen !== 1'b1 || bus.d_in !== b)
      $display("FAIL recover: seen=%b d_in=%h, expected 1 %h", seen, bus.d_in, b);
    else n_pass++;
    ack_cycle();
  endtask

  task automatic test_full_duplex();
    logic       seen;
    logic [7:0] bt, br;
    bt = 8'($urandom);
    br = 8'($urandom);
    fork
      tx_frame(bt, 1, 1'b0);
      rx_send(br, 1'b1);
    join
    wait_ready(20, seen);
    n_total++;
    if (seen !== 1'b1 || bus.d_in !== br)
      $display("FAIL duplex_rx: seen=%b d_in=%h, expected 1 %h", seen, bus.d_in, br);
    else n_pass++;
    ack_cycle();
  endtask

  task automatic test_back_to_back();
    logic       seen;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    exp_q = {8'h00, 8'h81};
    lb = 1'b1;
    @(negedge clk);
    foreach (exp_q[k]) begin
      bus.d_out = exp_q[k];
      bus.start = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (bus.done === 1'b1) seen = 1'b1;
      end
      n_total++;
      if (seen !== 1'b1) $display("FAIL lb_done byte=%h: done never rose, expected 1", exp_q[k]);
      else n_pass++;
      bus.start = 1'b0;
      @(negedge clk);
    end
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      wait_ready(20, seen);
      n_total++;
      if (seen !== 1'b1 || bus.d_in !== b)
        $display("FAIL lb_rx: seen=%b d_in=%h, expected 1 %h", seen, bus.d_in, b);
      else n_pass++;
      ack_cycle();
    end
    lb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    bus.d_out = 8'h00;
    bus.start = 1'b1;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.tx !== 1'b1 || bus.done !== 1'b0 || bus.d_ready !== 1'b0 || bus.d_in !== 8'h00)
      $display("FAIL reset_mid: tx=%b done=%b d_ready=%b d_in=%h, expected 1 0 0 00",
               bus.tx, bus.done, bus.d_ready, bus.d_in);
    else n_pass++;
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tx_frame(8'($urandom), 2, 1'b0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    bus.d_out = 8'h00;
    test_reset();
    test_tx();
    test_rx();
    test_overrun();
    test_glitch_and_framing();
    test_full_duplex();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_serdes.md
UART_SERDES -- requirements
Module: uart_serdes

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868 (100 MHz / 115200 baud), SHALL set clock cycles per serial bit; legal values are 4 or more.
REQ-002 clk  in  1  single clock; all logic SHALL be on the rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 rx  in  1  serial input, asynchronous to clk, idle high.
REQ-005 tx  out  1  serial output, idle high.
REQ-006 d_out  in  8  byte to transmit.
REQ-007 start  in  1  transmit request, a level held by the producer.
REQ-008 done  out  1  transmit complete, a level.
REQ-009 d_in  out  8  received byte.
REQ-010 d_ready  out  1  received byte valid, a level.
REQ-011 ack  in  1  consumer acknowledge for d_in, a level.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, one stop bit 1; each bit lasts exactly CLKS_PER_BIT cycles.
REQ-013 TX FSM states SHALL be IDLE, START, DATA, STOP, DONE.
REQ-014 IDLE: tx=1; when start=1, go to START on the next cycle.
REQ-015 TX SHALL latch d_out on the last cycle of the START bit, which tolerates a FIFO read completing up to 2 cycles after start rises.
REQ-016 DATA then STOP SHALL follow; after the full stop bit, enter DONE with done=1 and tx=1.
REQ-017 DONE SHALL hold done=1 until start=0; then done=0 and return to IDLE in one cycle.
REQ-018 start going low before DONE SHALL NOT abort the frame.
REQ-019 No new frame SHALL begin until done has dropped (4-phase handshake).
REQ-020 RX SHALL pass rx through a 2-flop synchronizer before any use.
REQ-021 RX FSM states SHALL be IDLE, START, DATA, STOP, HOLD.
REQ-022 A falling edge in IDLE enters START; the start bit SHALL be resampled at mid-bit (CLKS_PER_BIT/2), and if high, RX SHALL treat it as a glitch and return to IDLE.
REQ-023 Data bits SHALL be sampled at mid-bit and shifted LSB first.
REQ-024 At the stop mid-bit: if 1, load d_in and enter HOLD with d_ready=1; if 0 (framing error), discard the byte and return to IDLE without asserting d_ready.
REQ-025 HOLD: d_in and d_ready SHALL stay stable until ack=1; then d_ready=0.
REQ-026 d_ready SHALL NOT reassert until ack has been seen low.
REQ-027 RX SHALL keep receiving the next frame while in HOLD, using a separate shift register.
REQ-028 A completed second byte SHALL be delivered once the handshake frees d_in; a third completed byte while a second is still pending SHALL overwrite the pending byte (overrun, oldest delivered byte kept).
REQ-029 TX and RX SHALL be fully independent; simultaneous activity SHALL be legal.

Reset
REQ-030 While rst_n=0: tx=1, done=0, d_ready=0, d_in=8'h00, both FSMs in IDLE, synchronizer flops at 1, bit counters at 0.
REQ-031 Reset mid-frame SHALL abort both directions immediately; tx returns to 1 asynchronously.

Structure
REQ-032 The FSM state encodings and the frame constants (DATA_BITS=8, STOP_LEVEL=1) SHALL live in a shared package uart_pkg.
REQ-033 One sub-module SHALL exist: uart_bit_timer (counter with mid-bit and end-bit strobes), instantiated once for TX and once for RX.
REQ-034 The byte FIFO SHALL remain a separate existing block, outside this module.

Verification (CLKS_PER_BIT=4)
REQ-035 start=1, d_out=8'hA5 -> tx = 0,1,0,1,0,0,1,0,1,1 for 4 cycles each; done=1 after 40 bit-cycles; start=0 -> done=0 the next cycle.
REQ-036 Drive a serial 8'h3C frame on rx -> d_ready=1 with d_in=8'h3C; ack=1 -> d_ready=0; ack=0; a second frame 8'hFF -> d_in=8'hFF.
REQ-037 2-cycle low glitch on rx -> no d_ready, FSM back in IDLE.
REQ-038 Frame with stop bit=0 -> byte discarded, d_ready stays 0.
REQ-039 Loopback tx to rx, send 8'h00 and 8'h81 back-to-back with start/done handshake -> same bytes received in order.
REQ-040 rst_n pulsed low mid-TX-frame -> tx=1 immediately; a clean frame follows after release.
